// File: rtl/hilo_mul_ctrl.sv
// rtl/hilo_mul_ctrl.sv - EX-stage HI/LO multiply controller driving the iterative shift-add multiplier
module hilo_mul_ctrl #(
  parameter int TIMEOUT = 40
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid_i,
  input  logic [2:0]  op_i,
  input  logic [31:0] src1_i,
  input  logic [31:0] src2_i,
  input  logic        flush_i,
  output logic        stallreq_o,
  output logic        res_valid_o,
  output logic [31:0] res_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        err_o,
  output logic        mul_start_o,
  output logic        mul_sign_o,
  output logic [31:0] mul_op1_o,
  output logic [31:0] mul_op2_o,
  input  logic [63:0] mul_result_i,
  input  logic        mul_ready_i
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_MUL   = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [63:0]   prod_q;
  logic [31:0]   op1_q, op2_q, hi_q, lo_q;
  logic          sign_q, is_mul_q, err_q;
  logic          is_mulop, mulreq, mt_ok;

  assign is_mulop = (op_i == OP_MULT) || (op_i == OP_MULTU) || (op_i == OP_MUL);
  assign mulreq   = req_valid_i & is_mulop & ~flush_i;
  assign mt_ok    = req_valid_i & ~flush_i;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= S_IDLE;
      cnt      <= '0;
      prod_q   <= '0;
      op1_q    <= '0;
      op2_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      sign_q   <= 1'b0;
      is_mul_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (mulreq) begin
            op1_q    <= src1_i;
            op2_q    <= src2_i;
            sign_q   <= (op_i != OP_MULTU);
            is_mul_q <= (op_i == OP_MUL);
            cnt      <= '0;
            state    <= S_BUSY;
          end else if (mt_ok && op_i == OP_MTHI) begin
            hi_q <= src1_i;
          end else if (mt_ok && op_i == OP_MTLO) begin
            lo_q <= src1_i;
          end
        end
        S_BUSY: begin
          cnt <= cnt + 1'b1;
          // Flush beats a same-cycle ready; ready beats the timeout on the last allowed cycle.
          if (flush_i) begin
            state <= S_IDLE;
          end else if (mul_ready_i) begin
            prod_q <= mul_result_i;
            state  <= S_DONE;
          end else if (cnt == CNT_LAST) begin
            err_q <= 1'b1;
            state <= S_IDLE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          if (!flush_i && !is_mul_q) begin
            hi_q <= prod_q[63:32];
            lo_q <= prod_q[31:0];
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Start is low in IDLE and DONE, giving the multiplier its mandatory idle cycle between ops.
  assign mul_start_o = (state == S_BUSY);
  assign mul_sign_o  = sign_q;
  assign mul_op1_o   = op1_q;
  assign mul_op2_o   = op2_q;
  assign stallreq_o  = (state == S_IDLE) ? mulreq : (state == S_BUSY);
  assign res_valid_o = (state == S_DONE) & ~flush_i;
  assign res_o       = prod_q[31:0];
  assign hi_o        = hi_q;
  assign lo_o        = lo_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_hilo_mul_ctrl.sv
// tb/tb_hilo_mul_ctrl.sv - scoreboard bench for hilo_mul_ctrl with a behavioural shift-add multiplier
module tb_hilo_mul_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        req_valid_i;
  logic [2:0]  op_i;
  logic [31:0] src1_i, src2_i;
  logic        flush_i;
  logic        stallreq_o, res_valid_o, err_o;
  logic [31:0] res_o, hi_o, lo_o;
  logic        mul_start_o, mul_sign_o;
  logic [31:0] mul_op1_o, mul_op2_o;
  logic [63:0] mul_result_i;
  logic        mul_ready_i;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] res;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;
  exp_t sb[$];

  logic [31:0] exp_op1 = '0, exp_op2 = '0;
  logic        exp_sign = 1'b0;
  logic        never_ready = 1'b0;
  logic [5:0]  scnt = '0;
  logic        pend = 1'b0;
  exp_t        pend_e;

  hilo_mul_ctrl #(.TIMEOUT(40)) dut (
    .clk(clk), .resetn(resetn), .req_valid_i(req_valid_i), .op_i(op_i),
    .src1_i(src1_i), .src2_i(src2_i), .flush_i(flush_i),
    .stallreq_o(stallreq_o), .res_valid_o(res_valid_o), .res_o(res_o),
    .hi_o(hi_o), .lo_o(lo_o), .err_o(err_o),
    .mul_start_o(mul_start_o), .mul_sign_o(mul_sign_o),
    .mul_op1_o(mul_op1_o), .mul_op2_o(mul_op2_o),
    .mul_result_i(mul_result_i), .mul_ready_i(mul_ready_i)
  );

  always #5 clk = ~clk;

  function automatic int kof(input logic [31:0] v, input logic s);
    logic [31:0] a;
    a = (s && v[31]) ? (~v + 32'd1) : v;
    for (int i = 31; i >= 0; i--) if (a[i]) return i + 1;
    return 0;
  endfunction

  // Team multiplier timing: ready on the (k+2)th start-high cycle.
  always @(posedge clk) scnt <= mul_start_o ? scnt + 6'd1 : 6'd0;

  always_comb begin
    logic [63:0] a64, b64;
    a64 = mul_sign_o ? {{32{mul_op1_o[31]}}, mul_op1_o} : {32'd0, mul_op1_o};
    b64 = mul_sign_o ? {{32{mul_op2_o[31]}}, mul_op2_o} : {32'd0, mul_op2_o};
    mul_result_i = a64 * b64;
    mul_ready_i  = mul_start_o && !never_ready && (int'(scnt) == kof(mul_op2_o, mul_sign_o) + 1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (resetn) begin
      if (pend) begin
        chk("hi_after_done", hi_o, pend_e.hi);
        chk("lo_after_done", lo_o, pend_e.lo);
        pend = 1'b0;
      end
      if (res_valid_o) begin
        if (sb.size() == 0) begin
          chk("unexpected_res_valid", 1'b1, 1'b0);
        end else begin
          pend_e = sb.pop_front();
          chk("res_o", res_o, pend_e.res);
          pend = 1'b1;
        end
      end
      if (mul_start_o) begin
        chk("mul_sign", mul_sign_o, exp_sign);
        chk("mul_op1_stable", mul_op1_o, exp_op1);
        chk("mul_op2_stable", mul_op2_o, exp_op2);
      end
    end
  end

  task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_op1 = a;
    exp_op2 = b;
    exp_sign = (op != 3'b010);
    req_valid_i = 1'b1;
    op_i = op;
    src1_i = a;
    src2_i = b;
  endtask

  task automatic idle_inputs();
    req_valid_i = 1'b0;
    op_i = 3'b000;
    src1_i = '0;
    src2_i = '0;
  endtask

  task automatic run_mul(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eres, input logic [31:0] ehi, input logic [31:0] elo,
                         input int elat);
    exp_t e;
    int n;
    e.res = eres; e.hi = ehi; e.lo = elo;
    @(posedge clk); #1;
    sb.push_back(e);
    drive(op, a, b);
    #1 chk("stall_on_accept", stallreq_o, 1'b1);
    n = 0;
    while (!res_valid_o && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("done_latency", n, elat);
    chk("stall_in_done", stallreq_o, 1'b0);
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
  endtask

  task automatic run_mt(input logic [2:0] op, input logic [31:0] a);
    @(posedge clk); #1;
    req_valid_i = 1'b1; op_i = op; src1_i = a; src2_i = 32'hDEAD_BEEF;
    #1 chk("mt_no_stall", stallreq_o, 1'b0);
    @(posedge clk); #1;
    idle_inputs();
  endtask

  initial begin
    int n;
    resetn = 1'b0;
    flush_i = 1'b0;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hi", hi_o, 0);
    chk("rst_lo", lo_o, 0);
    chk("rst_res", res_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_start", mul_start_o, 0);
    chk("rst_sign", mul_sign_o, 0);
    chk("rst_op1", mul_op1_o, 0);
    chk("rst_res_valid", res_valid_o, 0);
    resetn = 1'b1;

    run_mul(3'b001, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFA, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5);
    run_mul(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 32'h0000_0001, 35);

    run_mt(3'b101, 32'h0);
    chk("mtlo_lo", lo_o, 32'h0);
    run_mt(3'b100, 32'h1234_5678);
    chk("mthi_hi", hi_o, 32'h1234_5678);
    chk("mthi_lo_kept", lo_o, 32'h0);

    // Reserved op and flushed MTHI must not touch anything.
    @(posedge clk); #1;
    req_valid_i = 1'b1; op_i = 3'b111; src1_i = 32'h5555_5555;
    #1 chk("reserved_no_stall", stallreq_o, 1'b0);
    @(posedge clk); #1;
    op_i = 3'b100; flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0; idle_inputs();
    chk("flushed_mthi_hi", hi_o, 32'h1234_5678);

    run_mul(3'b011, 32'd7, 32'hFFFF_FFFB, 32'hFFFF_FFDD, 32'h1234_5678, 32'h0, 6);
    run_mul(3'b011, 32'h1234, 32'd0, 32'h0, 32'h1234_5678, 32'h0, 3);

    // Flush on the 4th BUSY cycle of MULT 5x9.
    @(posedge clk); #1;
    drive(3'b001, 32'd5, 32'd9);
    repeat (4) begin @(posedge clk); #1; end
    chk("busy_start_before_flush", mul_start_o, 1'b1);
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    idle_inputs();
    chk("flush_start_low", mul_start_o, 1'b0);
    chk("flush_stall_low", stallreq_o, 1'b0);
    chk("flush_hi_kept", hi_o, 32'h1234_5678);
    chk("flush_lo_kept", lo_o, 32'h0);
    run_mul(3'b001, 32'd5, 32'd9, 32'd45, 32'h0, 32'd45, 7);

    // Multiplier never answers: abort after 40 BUSY cycles.
    never_ready = 1'b1;
    @(posedge clk); #1;
    drive(3'b001, 32'd2, 32'd3);
    n = 0;
    while (!err_o && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("timeout_cycles", n, 41);
    idle_inputs();
    #1;
    chk("timeout_stall_low", stallreq_o, 1'b0);
    chk("timeout_start_low", mul_start_o, 1'b0);
    chk("timeout_hi_kept", hi_o, 32'h0);
    chk("timeout_lo_kept", lo_o, 32'd45);
    repeat (5) @(posedge clk);
    #1 chk("err_sticky", err_o, 1'b1);

    // Asynchronous reset in the middle of BUSY.
    @(posedge clk); #1;
    drive(3'b001, 32'd2, 32'd3);
    repeat (3) begin @(posedge clk); #1; end
    chk("busy_before_reset", mul_start_o, 1'b1);
    resetn = 1'b0;
    idle_inputs();
    #1;
    chk("arst_start", mul_start_o, 0);
    chk("arst_stall", stallreq_o, 0);
    chk("arst_err", err_o, 0);
    chk("arst_hi", hi_o, 0);
    chk("arst_lo", lo_o, 0);
    chk("arst_res", res_o, 0);
    chk("arst_sign", mul_sign_o, 0);
    chk("arst_op2", mul_op2_o, 0);
    @(posedge clk); #1;
    resetn = 1'b1;
    never_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk("scoreboard_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
